// File: rtl/reaction_round_ctrl.sv
// Reaction-game round sequencer: random pre-delay, GO light, ms reaction timing,
// false-start/timeout detection and best-time tracking.
module reaction_round_ctrl #(
   parameter int          MIN_DELAY_MS = 1000,
   parameter int          RAND_BITS    = 11,
   parameter int          TIMEOUT_MS   = 9999,
   parameter int          MS_W         = 14,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tick_ms,
   input  logic            start_btn,
   input  logic            react_btn,
   output logic [2:0]      state,
   output logic            led_go,
   output logic [MS_W-1:0] reaction_ms,
   output logic [MS_W-1:0] best_ms,
   output logic            result_valid,
   output logic            false_start,
   output logic            timeout,
   output logic            round_done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WAIT  = 3'd1;
   localparam logic [2:0] S_GO    = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_FALSE = 3'd4;
   localparam logic [2:0] S_TOUT  = 3'd5;

   localparam logic [15:0]     LFSR_MASK = 16'hB400;
   localparam logic [MS_W-1:0] MIN_D     = MS_W'(MIN_DELAY_MS);
   localparam logic [MS_W-1:0] TO_LAST   = MS_W'(TIMEOUT_MS - 1);
   localparam logic [MS_W-1:0] TO_VAL    = MS_W'(TIMEOUT_MS);
   localparam logic [MS_W-1:0] ONE       = MS_W'(1);

   logic [2:0]      r_state;
   logic [MS_W-1:0] r_delay_cnt;
   logic [MS_W-1:0] r_react_cnt;
   logic [MS_W-1:0] r_reaction_ms;
   logic [MS_W-1:0] r_best_ms;
   logic [15:0]     r_lfsr;
   logic            r_round_done;
   logic            r_start_q;
   logic            r_react_q;

   logic [2:0]      w_state_nxt;
   logic [MS_W-1:0] w_delay_nxt;
   logic [MS_W-1:0] w_react_nxt;
   logic [MS_W-1:0] w_reaction_nxt;
   logic [MS_W-1:0] w_best_nxt;
   logic [MS_W-1:0] w_delay_load;
   logic            w_start_rise;
   logic            w_react_rise;
   logic            w_round_end;

   function automatic logic [15:0] f_lfsr_next(input logic [15:0] v);
      f_lfsr_next = v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
   endfunction

   function automatic logic [MS_W-1:0] f_min(input logic [MS_W-1:0] a,
                                              input logic [MS_W-1:0] b);
      f_min = (b < a) ? b : a;
   endfunction

   assign w_start_rise = start_btn & ~r_start_q;
   assign w_react_rise = react_btn & ~r_react_q;
   assign w_delay_load = MIN_D + MS_W'(r_lfsr[RAND_BITS-1:0]);

   always_comb begin
      w_state_nxt    = r_state;
      w_delay_nxt    = r_delay_cnt;
      w_react_nxt    = r_react_cnt;
      w_reaction_nxt = r_reaction_ms;
      w_best_nxt     = r_best_ms;
      case (r_state)
         S_IDLE, S_DONE, S_FALSE, S_TOUT: begin
            if (w_start_rise) begin
               w_delay_nxt = w_delay_load;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            // An early press beats a same-cycle final tick.
            if (w_react_rise) begin
               w_state_nxt = S_FALSE;
            end else if (tick_ms) begin
               if (r_delay_cnt <= ONE) begin
                  w_state_nxt = S_GO;
                  w_react_nxt = '0;
               end else begin
                  w_delay_nxt = r_delay_cnt - ONE;
               end
            end
         end
         S_GO: begin
            // The pre-increment count is captured, so a same-cycle tick is not charged.
            if (w_react_rise) begin
               w_reaction_nxt = r_react_cnt;
               w_best_nxt     = f_min(r_best_ms, r_react_cnt);
               w_state_nxt    = S_DONE;
            end else if (tick_ms) begin
               if (r_react_cnt == TO_LAST) begin
                  w_reaction_nxt = TO_VAL;
                  w_state_nxt    = S_TOUT;
               end else begin
                  w_react_nxt = r_react_cnt + ONE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign w_round_end = (w_state_nxt != r_state) &&
                        ((w_state_nxt == S_DONE) || (w_state_nxt == S_FALSE) ||
                         (w_state_nxt == S_TOUT));

   // Edge registers reset high so a button held through reset yields no edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_delay_cnt   <= '0;
         r_react_cnt   <= '0;
         r_reaction_ms <= '0;
         r_best_ms     <= '1;
         r_lfsr        <= LFSR_SEED;
         r_round_done  <= 1'b0;
         r_start_q     <= 1'b1;
         r_react_q     <= 1'b1;
      end else begin
         r_state       <= w_state_nxt;
         r_delay_cnt   <= w_delay_nxt;
         r_react_cnt   <= w_react_nxt;
         r_reaction_ms <= w_reaction_nxt;
         r_best_ms     <= w_best_nxt;
         r_lfsr        <= f_lfsr_next(r_lfsr);
         r_round_done  <= w_round_end;
         r_start_q     <= start_btn;
         r_react_q     <= react_btn;
      end
   end

   assign state        = r_state;
   assign led_go       = (r_state == S_GO);
   assign result_valid = (r_state == S_DONE);
   assign false_start  = (r_state == S_FALSE);
   assign timeout      = (r_state == S_TOUT);
   assign reaction_ms  = r_reaction_ms;
   assign best_ms      = r_best_ms;
   assign round_done   = r_round_done;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Scoreboard bench for reaction_round_ctrl: directed rounds push expected results,
// a monitor checks them on every round_done pulse.
module tb_reaction_round_ctrl;

   localparam int MS_W = 14;

   logic            clk;
   logic            rst;
   logic            tick_ms;
   logic            start_btn;
   logic            react_btn;
   logic [2:0]      state;
   logic            led_go;
   logic [MS_W-1:0] reaction_ms;
   logic [MS_W-1:0] best_ms;
   logic            result_valid;
   logic            false_start;
   logic            timeout;
   logic            round_done;

   reaction_round_ctrl #(
      .MIN_DELAY_MS(5),
      .RAND_BITS(2),
      .TIMEOUT_MS(20),
      .MS_W(MS_W),
      .LFSR_SEED(16'hACE1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .tick_ms(tick_ms),
      .start_btn(start_btn),
      .react_btn(react_btn),
      .state(state),
      .led_go(led_go),
      .reaction_ms(reaction_ms),
      .best_ms(best_ms),
      .result_valid(result_valid),
      .false_start(false_start),
      .timeout(timeout),
      .round_done(round_done)
   );

   typedef struct packed {
      logic [2:0]      st;
      logic [MS_W-1:0] rms;
      logic [MS_W-1:0] best;
   } exp_t;

   exp_t        sb_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic        s_lvl   = 1'b0;
   logic        r_lvl   = 1'b0;
   logic [15:0] m_lfsr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference LFSR kept in lockstep with the DUT so the bench knows each random delay.
   always @(posedge clk or posedge rst) begin
      if (rst) m_lfsr <= 16'hACE1;
      else     m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic push_exp(input logic [2:0] st, input logic [MS_W-1:0] rms,
                           input logic [MS_W-1:0] best);
      exp_t e;
      e.st   = st;
      e.rms  = rms;
      e.best = best;
      sb_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (!rst && round_done) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_round_done: got state %0d, expected no round end", state);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_state",        32'(state),        32'(e.st));
            chk("sb_reaction_ms",  32'(reaction_ms),  32'(e.rms));
            chk("sb_best_ms",      32'(best_ms),      32'(e.best));
            chk("sb_result_valid", 32'(result_valid), 32'(e.st == 3'd3));
            chk("sb_false_start",  32'(false_start),  32'(e.st == 3'd4));
            chk("sb_timeout",      32'(timeout),      32'(e.st == 3'd5));
            chk("sb_led_go",       32'(led_go),       32'd0);
         end
      end
   end

   task automatic step(input logic t);
      @(negedge clk);
      tick_ms   = t;
      start_btn = s_lvl;
      react_btn = r_lvl;
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b1);
         repeat (3) step(1'b0);
      end
   endtask

   task automatic start_round(input int want, output int dly);
      int found;
      found = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         tick_ms   = 1'b0;
         start_btn = 1'b0;
         react_btn = r_lvl;
         if (want < 0 || int'(m_lfsr[1:0]) == want) begin
            found = 1;
            break;
         end
      end
      if (found == 0) chk("lfsr_phase_found", 32'd0, 32'd1);
      dly       = 5 + int'(m_lfsr[1:0]);
      start_btn = 1'b1;
      @(posedge clk);
      #1;
      chk("wait_entry", 32'(state), 32'd1);
   endtask

   task automatic to_go(input int dly);
      ticks(dly - 1);
      chk("wait_hold", 32'(state), 32'd1);
      step(1'b1);
      chk("go_entry", 32'(state), 32'd2);
      chk("go_led", 32'(led_go), 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int   dly;
      logic seen;
      rst       = 1'b1;
      tick_ms   = 1'b0;
      start_btn = 1'b0;
      react_btn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // 1: reset state and quiet idle
      chk("rst_state",    32'(state),       32'd0);
      chk("rst_led_go",   32'(led_go),      32'd0);
      chk("rst_best",     32'(best_ms),     32'h3FFF);
      chk("rst_reaction", 32'(reaction_ms), 32'd0);
      chk("rst_done",     32'(round_done),  32'd0);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step(i % 4 == 0);
         seen = seen | round_done;
      end
      chk("idle_no_round_done", 32'(seen), 32'd0);
      chk("idle_state", 32'(state), 32'd0);

      // 2: delay of 7 ticks, react after 3 GO ticks
      start_round(2, dly);
      chk("delay_value", 32'(dly), 32'd7);
      to_go(dly);
      repeat (3) step(1'b0);
      ticks(3);
      push_exp(3'd3, 14'd3, 14'd3);
      r_lvl = 1'b1;
      step(1'b0);
      chk("done_state", 32'(state), 32'd3);
      chk("done_pulse", 32'(round_done), 32'd1);
      r_lvl = 1'b0;
      step(1'b0);
      chk("done_pulse_one_clk", 32'(round_done), 32'd0);

      // 3: false start, then a second press is ignored
      start_round(-1, dly);
      ticks(2);
      push_exp(3'd4, 14'd3, 14'd3);
      r_lvl = 1'b1;
      step(1'b0);
      chk("false_state", 32'(state), 32'd4);
      chk("false_flag", 32'(false_start), 32'd1);
      r_lvl = 1'b0;
      repeat (2) step(1'b0);
      r_lvl = 1'b1;
      step(1'b0);
      r_lvl = 1'b0;
      step(1'b1);
      chk("false_hold_state", 32'(state), 32'd4);
      chk("false_hold_reaction", 32'(reaction_ms), 32'd3);

      // 4: timeout on the 20th GO tick
      start_round(-1, dly);
      to_go(dly);
      repeat (3) step(1'b0);
      ticks(19);
      chk("pre_timeout_state", 32'(state), 32'd2);
      push_exp(3'd5, 14'd20, 14'd3);
      step(1'b1);
      chk("tout_flag", 32'(timeout), 32'd1);
      repeat (3) step(1'b0);

      // 5a: react on the same cycle as a GO tick
      start_round(-1, dly);
      to_go(dly);
      repeat (3) step(1'b0);
      ticks(7);
      push_exp(3'd3, 14'd7, 14'd3);
      r_lvl = 1'b1;
      step(1'b1);
      chk("tick_react_state", 32'(state), 32'd3);
      r_lvl = 1'b0;

      // 5b: react on the final WAIT tick
      start_round(-1, dly);
      ticks(dly - 1);
      push_exp(3'd4, 14'd7, 14'd3);
      r_lvl = 1'b1;
      step(1'b1);
      chk("final_wait_tick_react", 32'(state), 32'd4);
      r_lvl = 1'b0;

      // 5c: react on the timeout tick
      start_round(-1, dly);
      to_go(dly);
      repeat (3) step(1'b0);
      ticks(19);
      push_exp(3'd3, 14'd19, 14'd3);
      r_lvl = 1'b1;
      step(1'b1);
      chk("timeout_tick_react", 32'(state), 32'd3);
      r_lvl = 1'b0;

      // 5d: a faster reaction lowers best_ms
      start_round(-1, dly);
      to_go(dly);
      repeat (3) step(1'b0);
      ticks(1);
      push_exp(3'd3, 14'd1, 14'd1);
      r_lvl = 1'b1;
      step(1'b0);
      r_lvl = 1'b0;
      step(1'b0);
      chk("best_lowered", 32'(best_ms), 32'd1);

      // 6: reset during GO with start held through reset
      start_round(-1, dly);
      to_go(dly);
      repeat (2) step(1'b0);
      @(negedge clk);
      rst       = 1'b1;
      s_lvl     = 1'b1;
      start_btn = 1'b1;
      #1;
      chk("async_rst_state", 32'(state),   32'd0);
      chk("async_rst_best",  32'(best_ms), 32'h3FFF);
      chk("async_rst_led",   32'(led_go),  32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 40; i++) step(i % 4 == 0);
      chk("held_start_no_round", 32'(state), 32'd0);
      chk("held_start_reaction", 32'(reaction_ms), 32'd0);
      s_lvl = 1'b0;
      repeat (4) step(1'b0);

      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
